sequence_pattern_tx: RTL and testbench
======================================

// Module: sequence_pattern_tx
// PURPOSE
//   Transmit-side counterpart of the serial sequence detectors. Accepts a pattern
//     request over a valid/ready handshake and serializes it one bit per clock, MSB-first.
//   Optional repeats, with programmable idle gaps between repetitions.
//   Output stream drives a detector's input_bit for self-checking stimulus and loopback tests.
// PARAMETERS
//   PAT_W      8  width of pattern register; max bits per pattern
//   CNT_W      4  width of repeat counter; pattern is sent req_repeat+1 times
//   GAP_BITS   1  idle cycles inserted between repetitions (0 = back-to-back, for overlap tests)
//   IDLE_LEVEL 0  value driven on serial_out when no bit is being sent
// PORTS
//   clk          in   1                  rising-edge clock
//   reset_n      in   1                  async active-low reset
//   req_valid    in   1                  request present
//   req_ready    out  1                  block can accept a request (high only in IDLE)
//   req_pattern  in   PAT_W              bits to send; bit [req_len-1] is sent first
//   req_len      in   $clog2(PAT_W)+1    pattern length in bits, 0..PAT_W
//   req_repeat   in   CNT_W              extra repetitions (0 = send once)
//   serial_out   out  1                  serial bit stream (connects to detector input_bit)
//   bit_valid    out  1                  serial_out carries a pattern (or parity) bit this cycle
//   busy         out  1                  request in progress (state != IDLE)
//   done         out  1                  one-cycle pulse after final bit of final repetition
// BEHAVIOUR
//   Reset (async assert, sync release):
//     - state=IDLE, serial_out=IDLE_LEVEL, bit_valid=0, busy=0, done=0, req_ready=1.
//   Handshake:
//     - Request accepted when req_valid && req_ready.
//     - Pattern, length and repeat are captured at acceptance; later input changes are ignored.
//     - req_valid while busy is ignored; it is not queued.
//     - req_ready = (state==IDLE) && !done is false; see done rule below.
//   FSM states: IDLE -> SEND -> (PARITY) -> GAP -> SEND ... -> IDLE.
//     - IDLE: on accept, go to SEND. If len==0, go to IDLE with done=1 the next cycle and send no bits.
//     - SEND: serial_out is registered. First bit appears the cycle after acceptance (latency 1).
//         - Bit index counts len-1 down to 0, one bit per cycle, with bit_valid=1.
//         - After index 0: go to PARITY if enabled, else the end-of-repetition step.
//     - End-of-repetition:
//         - If reps_left>0: decrement reps_left. Go to GAP if GAP_BITS>0, else directly to SEND
//           (next bit contiguous).
//         - If reps_left==0: go to IDLE.
//     - GAP: GAP_BITS cycles with serial_out=IDLE_LEVEL and bit_valid=0, then SEND.
//   done:
//     - Asserts for exactly 1 cycle, in the first IDLE cycle after the last bit.
//     - req_ready is also high in that cycle, so a new request may be accepted with no bubble.
//   Outputs outside SEND/PARITY: serial_out=IDLE_LEVEL, bit_valid=0.
//   Widths: bit counter $clog2(PAT_W) bits; repeat counter CNT_W bits, no wrap (stops at 0).
//   req_len > PAT_W: clamped to PAT_W at capture.
//   reset_n asserted mid-frame: immediate abort to reset values. No done pulse; the partial pattern is lost.
// CONFIGURATION
//   Macro SEQ_TX_PARITY_EN.
//   Defined:
//     - PARITY state follows each repetition's last bit.
//     - Sends one even-parity bit: XOR of the len pattern bits, bit_valid=1.
//     - Adds 1 cycle per repetition.
//   Undefined: no PARITY state; it is excluded from the enum and the logic.
// STRUCTURE
//   Package seq_pkg holds shared definitions:
//     - typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_PARITY, ST_GAP} tx_state_t
//     - localparam logic [3:0] SEQ_1011 = 4'b1011 (the canonical detect pattern), shared with detectors
//   Sub-module: none. FSM, bit counter, gap counter and repeat counter live in one module.
// TESTING (clk period 10ns, reset_n low for 2 cycles; cycle N = N cycles after accept)
//   T1:
//     - Stimulus: pattern=8'h0B, len=4, repeat=0.
//     - Response: serial_out=1,0,1,1 with bit_valid=1 in cycles 1-4; done=1 in cycle 5; req_ready=1 in cycle 5.
//   T2:
//     - Stimulus: pattern=8'h0B, len=4, repeat=2, GAP_BITS=1.
//     - Response: stream 1011_0_1011_0_1011, with bit_valid low only in the gap cycles; single done in cycle 15.
//   T3:
//     - Stimulus: GAP_BITS=0, pattern=8'h0B, len=4, repeat=1, looped into the 1011 Mealy detector.
//     - Response: stream 10111011; detected pulses twice.
//   T4:
//     - Stimulus: len=0 accepted.
//     - Response: no bit_valid; done=1 in cycle 1.
//     - Stimulus: req_valid held during busy.
//     - Response: no second frame until the returned req_ready handshakes.
//   T5:
//     - Stimulus: reset_n low in cycle 2 of an 8-bit frame.
//     - Response: serial_out=0 and bit_valid=0 asynchronously; no done; next request behaves as T1.
//   T6 (SEQ_TX_PARITY_EN):
//     - Stimulus: pattern 4'b1011.
//     - Response: bits 1,0,1,1,1 (parity=1); done in cycle 6.
//     - Stimulus: pattern 4'b1001.
//     - Response: parity bit=0.

Source files
------------

// File: rtl/sequence_pattern_tx_pkg.sv
// -----------------------------------------------------------------------------
// seq_pkg: definitions shared by the serial pattern transmitter and the
// sequence detectors it drives.
//   tx_state_t : transmitter FSM encoding. ST_PARITY exists only when
//                SEQ_TX_PARITY_EN is defined.
//   SEQ_1011   : canonical detect pattern.
// Configuration macro: SEQ_TX_PARITY_EN
// -----------------------------------------------------------------------------
package seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEND   = 2'd1,
`ifdef SEQ_TX_PARITY_EN
        ST_PARITY = 2'd2,
`endif
        ST_GAP    = 2'd3
    } tx_state_t;

    localparam logic [3:0] SEQ_1011 = 4'b1011;

endpackage

// File: rtl/sequence_pattern_tx_if.sv
// -----------------------------------------------------------------------------
// sequence_pattern_tx_if: request handshake plus serial output bundle of the
// pattern transmitter.
//   master : request source (drives req_valid/req_pattern/req_len/req_repeat,
//            observes req_ready and the serial stream)
//   slave  : the transmitter
// -----------------------------------------------------------------------------
interface sequence_pattern_tx_if #(
    parameter int PAT_W = 8,
    parameter int CNT_W = 4
);
    localparam int LEN_W = $clog2(PAT_W) + 1;

    logic             req_valid;
    logic             req_ready;
    logic [PAT_W-1:0] req_pattern;
    logic [LEN_W-1:0] req_len;
    logic [CNT_W-1:0] req_repeat;
    logic             serial_out;
    logic             bit_valid;
    logic             busy;
    logic             done;

    modport master (
        output req_valid, req_pattern, req_len, req_repeat,
        input  req_ready, serial_out, bit_valid, busy, done
    );

    modport slave (
        input  req_valid, req_pattern, req_len, req_repeat,
        output req_ready, serial_out, bit_valid, busy, done
    );
endinterface

// File: rtl/sequence_pattern_tx.sv
// -----------------------------------------------------------------------------
// sequence_pattern_tx: accepts a pattern request and serializes it MSB-first,
// one bit per clock, optionally repeated with idle gaps between repetitions.
// Ports:
//   clk      : rising-edge clock
//   reset_n  : asynchronous active-low reset
//   bus      : sequence_pattern_tx_if.slave
//              req_valid/req_ready handshake, req_pattern, req_len (0..PAT_W,
//              clamped), req_repeat (extra repetitions), serial_out,
//              bit_valid, busy, done (1-cycle pulse after the final bit)
// Parameters: PAT_W, CNT_W, GAP_BITS (idle cycles between repetitions),
//             IDLE_LEVEL (serial_out level when no bit is sent)
// Configuration macro: SEQ_TX_PARITY_EN appends one even-parity bit after
//   each repetition.
// -----------------------------------------------------------------------------
module sequence_pattern_tx
    import seq_pkg::*;
#(
    parameter int PAT_W      = 8,
    parameter int CNT_W      = 4,
    parameter int GAP_BITS   = 1,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    sequence_pattern_tx_if.slave  bus
);

    localparam int LEN_W = $clog2(PAT_W) + 1;
    localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam int GAP_W = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;

    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
        return (l > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : l;
    endfunction

    // Ones in the low l bits; bits above the length never reach the output
    // or the parity.
    function automatic logic [PAT_W-1:0] len_mask(input logic [LEN_W-1:0] l);
        logic [PAT_W:0] m;
        m = ((PAT_W+1)'(1) << l) - (PAT_W+1)'(1);
        return m[PAT_W-1:0];
    endfunction

    tx_state_t        state_q;
    logic [IDX_W-1:0] idx_q;
    logic [CNT_W-1:0] reps_q;
    logic [GAP_W-1:0] gap_q;
    logic             serial_q;
    logic             bit_valid_q;
    logic             done_q;
    logic [PAT_W-1:0] pat_q;
    logic [LEN_W-1:0] len_q;

    logic [LEN_W-1:0] len_d;
    logic [PAT_W-1:0] pat_d;
    logic [IDX_W-1:0] first_idx_d;
    logic [IDX_W-1:0] restart_idx;
    logic             accept;
    logic             rep_end;

    assign accept = bus.req_valid && (state_q == ST_IDLE);

    always_comb begin
        len_d       = clamp_len(bus.req_len);
        pat_d       = bus.req_pattern & len_mask(len_d);
        first_idx_d = IDX_W'(len_d - LEN_W'(1));
        restart_idx = IDX_W'(len_q - LEN_W'(1));
`ifdef SEQ_TX_PARITY_EN
        rep_end     = (state_q == ST_PARITY);
`else
        rep_end     = (state_q == ST_SEND) && (idx_q == '0);
`endif
    end

    // Pattern data is only meaningful while busy, so it carries no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            pat_q <= pat_d;
            len_q <= len_d;
        end
    end

    // Outputs are registered: each branch loads what the next cycle drives.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            reps_q      <= '0;
            gap_q       <= '0;
            serial_q    <= IDLE_LEVEL;
            bit_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (rep_end) begin
                if (reps_q != '0) begin
                    reps_q <= reps_q - 1'b1;
                    if (GAP_BITS > 0) begin
                        state_q     <= ST_GAP;
                        gap_q       <= GAP_W'(GAP_BITS - 1);
                        serial_q    <= IDLE_LEVEL;
                        bit_valid_q <= 1'b0;
                    end else begin
                        state_q     <= ST_SEND;
                        idx_q       <= restart_idx;
                        serial_q    <= pat_q[restart_idx];
                        bit_valid_q <= 1'b1;
                    end
                end else begin
                    state_q     <= ST_IDLE;
                    done_q      <= 1'b1;
                    serial_q    <= IDLE_LEVEL;
                    bit_valid_q <= 1'b0;
                end
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (accept) begin
                            reps_q <= bus.req_repeat;
                            // A zero-length request completes without sending.
                            if (len_d == '0) begin
                                done_q <= 1'b1;
                            end else begin
                                state_q     <= ST_SEND;
                                idx_q       <= first_idx_d;
                                serial_q    <= pat_d[first_idx_d];
                                bit_valid_q <= 1'b1;
                            end
                        end
                    end
                    ST_SEND: begin
                        if (idx_q != '0) begin
                            idx_q    <= idx_q - 1'b1;
                            serial_q <= pat_q[idx_q - 1'b1];
                        end
`ifdef SEQ_TX_PARITY_EN
                        else begin
                            state_q  <= ST_PARITY;
                            serial_q <= ^pat_q;
                        end
`endif
                    end
                    ST_GAP: begin
                        if (gap_q == '0) begin
                            state_q     <= ST_SEND;
                            idx_q       <= restart_idx;
                            serial_q    <= pat_q[restart_idx];
                            bit_valid_q <= 1'b1;
                        end else begin
                            gap_q <= gap_q - 1'b1;
                        end
                    end
                    default: begin
                        state_q     <= ST_IDLE;
                        serial_q    <= IDLE_LEVEL;
                        bit_valid_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.req_ready  = (state_q == ST_IDLE);
    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.serial_out = serial_q;
    assign bus.bit_valid  = bit_valid_q;
    assign bus.done       = done_q;

endmodule

// File: tb/tb_sequence_pattern_tx.sv
module tb_sequence_pattern_tx;
    import seq_pkg::*;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    sequence_pattern_tx_if #(.PAT_W(8), .CNT_W(4)) ifa ();
    sequence_pattern_tx_if #(.PAT_W(8), .CNT_W(4)) ifb ();

    sequence_pattern_tx #(.PAT_W(8), .CNT_W(4), .GAP_BITS(1), .IDLE_LEVEL(1'b0)) dut_a (
        .clk(clk), .reset_n(reset_n), .bus(ifa.slave)
    );
    sequence_pattern_tx #(.PAT_W(8), .CNT_W(4), .GAP_BITS(0), .IDLE_LEVEL(1'b0)) dut_b (
        .clk(clk), .reset_n(reset_n), .bus(ifb.slave)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // 1011 Mealy detector fed by the gapless instance.
    logic [3:0] det_sh = 4'b0000;
    int det_cnt = 0;
    always @(posedge clk) begin
        if (ifb.bit_valid) begin
            if ({det_sh[2:0], ifb.serial_out} == SEQ_1011) det_cnt = det_cnt + 1;
            det_sh <= {det_sh[2:0], ifb.serial_out};
        end
    end

    // Waits (bounded) for req_ready, presents one request, releases it after
    // the accepting edge and scrambles the inputs to prove they were captured.
    task automatic send_a(input logic [7:0] pat, input logic [3:0] len, input logic [3:0] rep);
        int n = 0;
        @(negedge clk);
        while (!ifa.req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", ifa.req_ready, 1'b1);
        ifa.req_pattern = pat;
        ifa.req_len     = len;
        ifa.req_repeat  = rep;
        ifa.req_valid   = 1'b1;
        @(posedge clk);
        #1;
        ifa.req_valid   = 1'b0;
        ifa.req_pattern = 8'h5A;
        ifa.req_len     = 4'd7;
        ifa.req_repeat  = 4'd3;
    endtask

    // exp: one char per cycle after accept; '0'/'1' valid bit, '.' gap cycle.
    // The cycle after the string is the done cycle.
    task automatic run_vec(input string nm, input logic [7:0] pat, input logic [3:0] len,
                           input logic [3:0] rep, input string exp);
        byte ch;
        send_a(pat, len, rep);
        for (int c = 1; c <= exp.len(); c++) begin
            @(negedge clk);
            ch = exp[c-1];
            if (ch == ".") begin
                chk($sformatf("%s.c%0d.bit_valid", nm, c), ifa.bit_valid, 1'b0);
                chk($sformatf("%s.c%0d.serial", nm, c), ifa.serial_out, 1'b0);
            end else begin
                chk($sformatf("%s.c%0d.bit_valid", nm, c), ifa.bit_valid, 1'b1);
                chk($sformatf("%s.c%0d.serial", nm, c), ifa.serial_out, (ch == "1"));
            end
            chk($sformatf("%s.c%0d.done", nm, c), ifa.done, 1'b0);
            chk($sformatf("%s.c%0d.busy", nm, c), ifa.busy, 1'b1);
        end
        @(negedge clk);
        chk($sformatf("%s.done", nm), ifa.done, 1'b1);
        chk($sformatf("%s.done_ready", nm), ifa.req_ready, 1'b1);
        chk($sformatf("%s.done_bit_valid", nm), ifa.bit_valid, 1'b0);
        @(negedge clk);
        chk($sformatf("%s.done_pulse_end", nm), ifa.done, 1'b0);
    endtask

    typedef struct {
        string      nm;
        logic [7:0] pat;
        logic [3:0] len;
        logic [3:0] rep;
        string      exp;
    } vec_t;

    vec_t vecs[8];

    initial begin
        string hs;
        string s3;
        byte   ch;
        bit    saw_done;

`ifdef SEQ_TX_PARITY_EN
        vecs[0] = '{"T1_1011",    8'h0B, 4'd4,  4'd0, "10111"};
        vecs[1] = '{"T2_rep2",    8'h0B, 4'd4,  4'd2, "10111.10111.10111"};
        vecs[2] = '{"full_A5",    8'hA5, 4'd8,  4'd0, "101001010"};
        vecs[3] = '{"clamp_len",  8'h3C, 4'd15, 4'd0, "001111000"};
        vecs[4] = '{"len1_rep1",  8'h01, 4'd1,  4'd1, "11.11"};
        vecs[5] = '{"T4_len0",    8'hFF, 4'd0,  4'd3, ""};
        vecs[6] = '{"T6_1001",    8'h09, 4'd4,  4'd1, "10010.10010"};
        vecs[7] = '{"mask_hi",    8'hF6, 4'd3,  4'd0, "1100"};
        hs = "10111d10111d";
        s3 = "1011110111";
`else
        vecs[0] = '{"T1_1011",    8'h0B, 4'd4,  4'd0, "1011"};
        vecs[1] = '{"T2_rep2",    8'h0B, 4'd4,  4'd2, "1011.1011.1011"};
        vecs[2] = '{"full_A5",    8'hA5, 4'd8,  4'd0, "10100101"};
        vecs[3] = '{"clamp_len",  8'h3C, 4'd15, 4'd0, "00111100"};
        vecs[4] = '{"len1_rep1",  8'h01, 4'd1,  4'd1, "1.1"};
        vecs[5] = '{"T4_len0",    8'hFF, 4'd0,  4'd3, ""};
        vecs[6] = '{"rep1_1001",  8'h09, 4'd4,  4'd1, "1001.1001"};
        vecs[7] = '{"mask_hi",    8'hF6, 4'd3,  4'd0, "110"};
        hs = "1011d1011d";
        s3 = "10111011";
`endif

        // Reset
        ifa.req_valid = 1'b0; ifa.req_pattern = '0; ifa.req_len = '0; ifa.req_repeat = '0;
        ifb.req_valid = 1'b0; ifb.req_pattern = '0; ifb.req_len = '0; ifb.req_repeat = '0;
        reset_n = 1'b0;
        #1;
        chk("rst.ready", ifa.req_ready, 1'b1);
        chk("rst.busy", ifa.busy, 1'b0);
        chk("rst.done", ifa.done, 1'b0);
        chk("rst.bit_valid", ifa.bit_valid, 1'b0);
        chk("rst.serial", ifa.serial_out, 1'b0);
        chk("rst.b_ready", ifb.req_ready, 1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // Table-driven frames
        for (int i = 0; i < 8; i++)
            run_vec(vecs[i].nm, vecs[i].pat, vecs[i].len, vecs[i].rep, vecs[i].exp);

        // req_valid held through a frame: the second frame starts only
        // after the done-cycle handshake, with no bubble.
        @(negedge clk);
        ifa.req_pattern = 8'h0B; ifa.req_len = 4'd4; ifa.req_repeat = 4'd0;
        ifa.req_valid = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= hs.len(); c++) begin
            @(negedge clk);
            ch = hs[c-1];
            if (ch == "d") begin
                chk($sformatf("hold.c%0d.done", c), ifa.done, 1'b1);
                chk($sformatf("hold.c%0d.ready", c), ifa.req_ready, 1'b1);
                chk($sformatf("hold.c%0d.bit_valid", c), ifa.bit_valid, 1'b0);
            end else begin
                chk($sformatf("hold.c%0d.bit_valid", c), ifa.bit_valid, 1'b1);
                chk($sformatf("hold.c%0d.serial", c), ifa.serial_out, (ch == "1"));
                chk($sformatf("hold.c%0d.busy", c), ifa.busy, 1'b1);
                chk($sformatf("hold.c%0d.done", c), ifa.done, 1'b0);
            end
            if (c == hs.len() / 2 + 1) ifa.req_valid = 1'b0;
        end
        @(negedge clk);
        chk("hold.no_third_frame", ifa.busy, 1'b0);

        // Mid-frame reset abort
        send_a(8'hA5, 4'd8, 4'd0);
        @(negedge clk);
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("abort.serial", ifa.serial_out, 1'b0);
        chk("abort.bit_valid", ifa.bit_valid, 1'b0);
        chk("abort.busy", ifa.busy, 1'b0);
        chk("abort.ready", ifa.req_ready, 1'b1);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        saw_done = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (ifa.done) saw_done = 1'b1;
        end
        chk("abort.no_done", saw_done, 1'b0);
        run_vec("after_abort", 8'h0B, 4'd4, 4'd0, vecs[0].exp);

        // Gapless repeat looped into the 1011 detector
        det_cnt = 0;
        @(negedge clk);
        ifb.req_pattern = 8'h0B; ifb.req_len = 4'd4; ifb.req_repeat = 4'd1;
        ifb.req_valid = 1'b1;
        @(posedge clk);
        #1;
        ifb.req_valid = 1'b0;
        for (int c = 1; c <= s3.len(); c++) begin
            @(negedge clk);
            ch = s3[c-1];
            chk($sformatf("gapless.c%0d.bit_valid", c), ifb.bit_valid, 1'b1);
            chk($sformatf("gapless.c%0d.serial", c), ifb.serial_out, (ch == "1"));
        end
        @(negedge clk);
        chk("gapless.done", ifb.done, 1'b1);
        chk("gapless.detections", det_cnt, 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
